// File: rtl/sram_like_responder_if.sv
// sram-like bus between an initiator (master) and a responder (slave).
// Handshake: a request transfers on a rising clock edge where req && addr_ok
// (addr_ok never depends on req in the same cycle); data_ok is a one-cycle
// response pulse that the initiator must take unconditionally, in the same
// order the requests were accepted.
interface sram_like_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic [31:0] rdata;
  logic        data_ok;

  modport master (output req, wr, size, addr, wdata, input addr_ok, rdata, data_ok);
  modport slave  (input req, wr, size, addr, wdata, output addr_ok, rdata, data_ok);
endinterface

// File: rtl/sram_like_responder.sv
// sram_like_responder: responder end of the sram-like bus. Requests are served
// from an internal word-addressed memory at acceptance and answered in order
// after LATENCY cycles; up to OUTSTANDING requests may be in flight.
// Optional feature macro: SRAM_LIKE_RAND_STALL_EN adds LFSR-driven stalls on
// addr_ok and data_ok.
module sram_like_responder #(
  parameter int ADDR_W      = 16,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  sram_like_responder_if.slave  bus
);
  localparam int               PTR_W   = $clog2(OUTSTANDING);
  localparam int               CNT_W   = PTR_W + 1;
  localparam int               WORDS   = 1 << (ADDR_W - 2);
  localparam logic [3:0]       CD_INIT = 4'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUTSTANDING);

  // Memory contents are deliberately not reset.
  logic [31:0]       mem_q [WORDS];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ent_wr_q    [OUTSTANDING];
  logic              ent_wr_d    [OUTSTANDING];
  logic [31:0]       ent_rdata_q [OUTSTANDING];
  logic [31:0]       ent_rdata_d [OUTSTANDING];
  logic [3:0]        ent_cd_q    [OUTSTANDING];
  logic [3:0]        ent_cd_d    [OUTSTANDING];

  logic [ADDR_W-3:0] word_idx;
  logic [31:0]       mem_rd;
  logic [3:0]        be;
  logic              accept;
  logic              pop;
  logic              stall_aok;
  logic              stall_dok;
  logic              unused_addr_bits;

  // Upper address bits alias onto the same memory words.
  assign word_idx         = bus.addr[ADDR_W-1:2];
  assign unused_addr_bits = ^bus.addr[31:ADDR_W];
  assign mem_rd           = mem_q[word_idx];

`ifdef SRAM_LIKE_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11, stepping every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR state register, reseeded on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end

  assign stall_aok = (lfsr_q[1:0] == 2'b00);
  assign stall_dok = (lfsr_q[3:2] == 2'b00);
`else
  assign stall_aok = 1'b0;
  assign stall_dok = 1'b0;
`endif

  // Responses come from registered queue state only; a stalled head simply
  // keeps its zero countdown until the stall clears, so order is preserved.
  assign bus.data_ok = (count_q != '0) && (ent_cd_q[head_q] == 4'd0) && !stall_dok;
  assign pop         = bus.data_ok;
  // A full queue still accepts when the head retires in the same cycle.
  assign bus.addr_ok = resetn && ((count_q < CNT_MAX) || pop) && !stall_aok;
  assign accept      = bus.req && bus.addr_ok;
  assign bus.rdata   = (bus.data_ok && !ent_wr_q[head_q]) ? ent_rdata_q[head_q] : 32'h0;

  // Byte lane enables from transfer size and low address bits.
  always_comb begin
    be = 4'b1111;
    case (bus.size)
      2'd0:    be = 4'b0001 << bus.addr[1:0];
      2'd1:    be = bus.addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Memory write port: writes land at the accepting edge under byte enables.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  // Queue next state: countdowns tick, head retires on pop, tail enqueues.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < OUTSTANDING; i++) begin
      ent_wr_d[i]    = ent_wr_q[i];
      ent_rdata_d[i] = ent_rdata_q[i];
      ent_cd_d[i]    = (ent_cd_q[i] != 4'd0) ? ent_cd_q[i] - 4'd1 : ent_cd_q[i];
    end
    if (pop) head_d = head_q + 1'b1;
    if (accept) begin
      ent_wr_d[tail_q]    = bus.wr;
      ent_rdata_d[tail_q] = mem_rd;
      ent_cd_d[tail_q]    = CD_INIT;
      tail_d              = tail_q + 1'b1;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Queue state registers; reset drops every in-flight request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        ent_wr_q[i]    <= 1'b0;
        ent_rdata_q[i] <= 32'h0;
        ent_cd_q[i]    <= 4'd0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < OUTSTANDING; i++) begin
        ent_wr_q[i]    <= ent_wr_d[i];
        ent_rdata_q[i] <= ent_rdata_d[i];
        ent_cd_q[i]    <= ent_cd_d[i];
      end
    end
  end
endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: three instances (LATENCY 2, 4, 8; OUTSTANDING 4)
// driven from directed scenario tasks; responses are logged by a negedge monitor.
module tb_sram_like_responder;
  localparam int NB    = 3;
  localparam int DEPTH = 2048;

  // Clock and reset
  logic clk    = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sram_like_responder_if bus0 ();
  sram_like_responder_if bus1 ();
  sram_like_responder_if bus2 ();

  sram_like_responder #(.ADDR_W(16), .LATENCY(2), .OUTSTANDING(4)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
  sram_like_responder #(.ADDR_W(16), .LATENCY(4), .OUTSTANDING(4)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));
  sram_like_responder #(.ADDR_W(16), .LATENCY(8), .OUTSTANDING(4)) dut2 (.clk(clk), .resetn(resetn), .bus(bus2));

  logic [NB-1:0] req_s = '0;
  logic [NB-1:0] wr_s  = '0;
  logic [1:0]    size_s  [NB];
  logic [31:0]   addr_s  [NB];
  logic [31:0]   wdata_s [NB];
  logic [NB-1:0] aok_s;
  logic [NB-1:0] dok_s;
  logic [31:0]   rdata_s [NB];

  assign bus0.req = req_s[0]; assign bus0.wr = wr_s[0]; assign bus0.size = size_s[0];
  assign bus0.addr = addr_s[0]; assign bus0.wdata = wdata_s[0];
  assign aok_s[0] = bus0.addr_ok; assign dok_s[0] = bus0.data_ok; assign rdata_s[0] = bus0.rdata;
  assign bus1.req = req_s[1]; assign bus1.wr = wr_s[1]; assign bus1.size = size_s[1];
  assign bus1.addr = addr_s[1]; assign bus1.wdata = wdata_s[1];
  assign aok_s[1] = bus1.addr_ok; assign dok_s[1] = bus1.data_ok; assign rdata_s[1] = bus1.rdata;
  assign bus2.req = req_s[2]; assign bus2.wr = wr_s[2]; assign bus2.size = size_s[2];
  assign bus2.addr = addr_s[2]; assign bus2.wdata = wdata_s[2];
  assign aok_s[2] = bus2.addr_ok; assign dok_s[2] = bus2.data_ok; assign rdata_s[2] = bus2.rdata;

  int checks   = 0;
  int failures = 0;

  // Accept log (written by driver) and response log (written by monitor)
  int          acc_n   [NB] = '{0, 0, 0};
  int          acc_cyc [NB][DEPTH];
  int          stall_n [NB] = '{0, 0, 0};
  int          resp_n  [NB] = '{0, 0, 0};
  logic [31:0] resp_data [NB][DEPTH];
  int          resp_cyc  [NB][DEPTH];

  // Response monitor: data_ok observed at the negedge after edge cyc.
  always @(negedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (dok_s[b] && resp_n[b] < DEPTH) begin
        resp_data[b][resp_n[b]] <= rdata_s[b];
        resp_cyc[b][resp_n[b]]  <= cyc;
        resp_n[b]               <= resp_n[b] + 1;
      end
    end
  end

  // Driver: present a request at a negedge; it is accepted at the next posedge
  // once addr_ok is seen high.
  task automatic send(input int b, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    req_s[b] = 1'b1; wr_s[b] = w; size_s[b] = sz; addr_s[b] = a; wdata_s[b] = d;
    while (aok_s[b] !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    stall_n[b] += waited;
    if (aok_s[b] !== 1'b1) begin
      checks++; failures++;
      $display("FAIL accept_timeout bus%0d addr=%h got addr_ok=%b exp=1", b, a, aok_s[b]);
      req_s[b] = 1'b0;
    end else if (acc_n[b] < DEPTH) begin
      acc_cyc[b][acc_n[b]] = cyc + 1;
      acc_n[b]++;
    end
  endtask

  task automatic idle(input int b);
    @(negedge clk);
    req_s[b] = 1'b0;
  endtask

  task automatic wait_resp(input int b, input int target, input string name);
    int n;
    n = 0;
    while (resp_n[b] < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (resp_n[b] < target) begin
      failures++;
      $display("FAIL %s bus%0d got responses=%0d exp=%0d", name, b, resp_n[b], target);
    end
  endtask

  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    be_of = 4'b0001 << off;
      2'd1:    be_of = off[1] ? 4'b1100 : 4'b0011;
      default: be_of = 4'b1111;
    endcase
  endfunction

  task automatic test_reset();
    for (int b = 0; b < NB; b++) begin
      size_s[b] = 2'd2; addr_s[b] = 32'h0; wdata_s[b] = 32'h0;
    end
    #1 resetn = 1'b0;
    repeat (2) @(negedge clk);
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (aok_s[b] !== 1'b0) begin failures++; $display("FAIL reset_addr_ok bus%0d got=%b exp=0", b, aok_s[b]); end
      checks++;
      if (dok_s[b] !== 1'b0) begin failures++; $display("FAIL reset_data_ok bus%0d got=%b exp=0", b, dok_s[b]); end
      checks++;
      if (rdata_s[b] !== 32'h0) begin failures++; $display("FAIL reset_rdata bus%0d got=%h exp=0", b, rdata_s[b]); end
    end
    resetn = 1'b1;
    #1;
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (aok_s[b] !== 1'b1) begin failures++; $display("FAIL release_addr_ok bus%0d got=%b exp=1", b, aok_s[b]); end
    end
  endtask

  task automatic test_write_read();
    int ab, rb;
    ab = acc_n[0]; rb = resp_n[0];
    send(0, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
    send(0, 1'b0, 2'd2, 32'h100, 32'h0);
    idle(0);
    wait_resp(0, rb + 2, "wr_rd_resp");
    repeat (6) @(negedge clk);
    checks++;
    if (resp_n[0] !== rb + 2) begin failures++; $display("FAIL wr_rd_count got=%0d exp=%0d", resp_n[0] - rb, 2); end
    checks++;
    if (resp_data[0][rb] !== 32'h0) begin failures++; $display("FAIL wr_rd_write_rdata got=%h exp=0", resp_data[0][rb]); end
    checks++;
    if (resp_data[0][rb+1] !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_rd_read_rdata got=%h exp=deadbeef", resp_data[0][rb+1]); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (resp_cyc[0][rb+i] !== acc_cyc[0][ab+i] + 1) begin
        failures++;
        $display("FAIL wr_rd_latency resp%0d got_cycle=%0d exp_cycle=%0d", i, resp_cyc[0][rb+i], acc_cyc[0][ab+i] + 1);
      end
    end
  endtask

  task automatic test_subword();
    int rb;
    rb = resp_n[0];
    send(0, 1'b1, 2'd2, 32'h200, 32'h0);
    send(0, 1'b1, 2'd0, 32'h202, 32'h00AB0000);
    send(0, 1'b1, 2'd1, 32'h200, 32'h00001234);
    send(0, 1'b0, 2'd2, 32'h200, 32'h0);
    send(0, 1'b1, 2'd1, 32'h203, 32'hBEEF0000);
    send(0, 1'b0, 2'd3, 32'h201, 32'h0);
    idle(0);
    wait_resp(0, rb + 6, "subword_resp");
    checks++;
    if (resp_data[0][rb+3] !== 32'h00AB1234) begin failures++; $display("FAIL subword_byte_half got=%h exp=00ab1234", resp_data[0][rb+3]); end
    checks++;
    if (resp_data[0][rb+5] !== 32'hBEEF1234) begin failures++; $display("FAIL subword_upper_half got=%h exp=beef1234", resp_data[0][rb+5]); end
  endtask

  task automatic test_back_to_back();
    int ab, rb, sb;
    ab = acc_n[1]; rb = resp_n[1]; sb = stall_n[1];
    for (int i = 0; i < 8; i++) send(1, 1'b1, 2'd2, 32'h40 + 32'(4*i), 32'hA5000000 | 32'(i));
    for (int i = 0; i < 8; i++) send(1, 1'b0, 2'd2, 32'h40 + 32'(4*i), 32'h0);
    idle(1);
    wait_resp(1, rb + 16, "b2b_resp");
    checks++;
    if (stall_n[1] - sb !== 0) begin failures++; $display("FAIL b2b_addr_ok_drops got=%0d exp=0", stall_n[1] - sb); end
    checks++;
    if (resp_cyc[1][rb] !== acc_cyc[1][ab] + 3) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=%0d", resp_cyc[1][rb], acc_cyc[1][ab] + 3); end
    checks++;
    if (resp_cyc[1][rb+15] - resp_cyc[1][rb] !== 15) begin failures++; $display("FAIL b2b_consecutive got_span=%0d exp=15", resp_cyc[1][rb+15] - resp_cyc[1][rb]); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (resp_data[1][rb+8+i] !== (32'hA5000000 | 32'(i))) begin
        failures++;
        $display("FAIL b2b_read_data idx%0d got=%h exp=%h", i, resp_data[1][rb+8+i], 32'hA5000000 | 32'(i));
      end
    end
  endtask

  task automatic test_full_queue();
    int ab, rb, sb;
    ab = acc_n[2]; rb = resp_n[2]; sb = stall_n[2];
    for (int i = 0; i < 12; i++) send(2, 1'b1, 2'd2, 32'h80 + 32'(4*i), 32'h5A5A0000 | 32'(i));
    idle(2);
    wait_resp(2, rb + 12, "full_resp");
    checks++;
    if (stall_n[2] - sb !== 8) begin failures++; $display("FAIL full_stall_cycles got=%0d exp=8", stall_n[2] - sb); end
    checks++;
    if (acc_cyc[2][ab+4] - acc_cyc[2][ab] !== 8) begin failures++; $display("FAIL full_accept_rate_1 got=%0d exp=8", acc_cyc[2][ab+4] - acc_cyc[2][ab]); end
    checks++;
    if (acc_cyc[2][ab+8] - acc_cyc[2][ab+4] !== 8) begin failures++; $display("FAIL full_accept_rate_2 got=%0d exp=8", acc_cyc[2][ab+8] - acc_cyc[2][ab+4]); end
    checks++;
    if (resp_cyc[2][rb] !== acc_cyc[2][ab] + 7) begin failures++; $display("FAIL full_first_latency got=%0d exp=%0d", resp_cyc[2][rb], acc_cyc[2][ab] + 7); end
    checks++;
    if (resp_cyc[2][rb] !== acc_cyc[2][ab+4] - 1) begin failures++; $display("FAIL full_reopen_on_pop got=%0d exp=%0d", acc_cyc[2][ab+4] - 1, resp_cyc[2][rb]); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (resp_data[2][rb+i] !== 32'h0) begin failures++; $display("FAIL full_write_rdata idx%0d got=%h exp=0", i, resp_data[2][rb+i]); end
    end
  endtask

  task automatic test_reset_midflight();
    int rb;
    rb = resp_n[2];
    for (int i = 0; i < 3; i++) send(2, 1'b0, 2'd2, 32'h80 + 32'(4*i), 32'h0);
    idle(2);
    resetn = 1'b0;
    #1;
    checks++;
    if (aok_s[2] !== 1'b0) begin failures++; $display("FAIL midflight_reset_addr_ok got=%b exp=0", aok_s[2]); end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if (aok_s[2] !== 1'b1) begin failures++; $display("FAIL midflight_release_addr_ok got=%b exp=1", aok_s[2]); end
    repeat (30) @(negedge clk);
    checks++;
    if (resp_n[2] !== rb) begin failures++; $display("FAIL midflight_dropped got_responses=%0d exp=0", resp_n[2] - rb); end
  endtask

  task automatic test_random();
    logic [31:0] model [16];
    logic [31:0] exp_q [$];
    logic [31:0] a, d, hi, e;
    logic [1:0]  sz, off;
    logic [3:0]  be;
    logic        w;
    int          idx, rb, sb, total;
    rb = resp_n[0]; sb = stall_n[0];
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      send(0, 1'b1, 2'd2, 32'h400 + 32'(4*i), model[i]);
      exp_q.push_back(32'h0);
    end
    for (int n = 0; n < 1000; n++) begin
      idx = $urandom_range(0, 15);
      off = 2'($urandom_range(0, 3));
      sz  = 2'($urandom_range(0, 3));
      w   = 1'($urandom_range(0, 1));
      d   = $urandom;
      hi  = $urandom;
      a   = {hi[31:16], 16'h0400 + 16'(4*idx) + 16'(off)};
      send(0, w, sz, a, d);
      if (w) begin
        be = be_of(sz, off);
        for (int k = 0; k < 4; k++) if (be[k]) model[idx][8*k +: 8] = d[8*k +: 8];
        exp_q.push_back(32'h0);
      end else begin
        exp_q.push_back(model[idx]);
      end
    end
    idle(0);
    total = exp_q.size();
    wait_resp(0, rb + total, "random_resp");
    for (int i = 0; i < total; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (resp_data[0][rb+i] !== e) begin failures++; $display("FAIL random_rdata idx%0d got=%h exp=%h", i, resp_data[0][rb+i], e); end
    end
`ifdef SRAM_LIKE_RAND_STALL_EN
    checks++;
    if (stall_n[0] - sb <= 0) begin failures++; $display("FAIL random_stall_seen got=%0d exp>0", stall_n[0] - sb); end
`else
    checks++;
    if (stall_n[0] - sb !== 0) begin failures++; $display("FAIL random_no_stall got=%0d exp=0", stall_n[0] - sb); end
`endif
  endtask

  initial begin
    test_reset();
`ifndef SRAM_LIKE_RAND_STALL_EN
    test_write_read();
`endif
    test_subword();
`ifndef SRAM_LIKE_RAND_STALL_EN
    test_back_to_back();
    test_full_queue();
`endif
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog simulation exceeded time bound at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sram_like_responder.md
# sram_like_responder

Responder end of the sram-like bus: it accepts requests from an initiator such as the CPU core or the cache miss ports, and returns in-order responses after a fixed, configurable latency. Requests are served from an internal word-addressed memory, and up to OUTSTANDING requests may be in flight at once. It sits behind the inst/data sram-like ports in simulation SoCs and unit benches, replacing the AXI bridge and RAM, so the pipeline and caches can be exercised against a well-defined slave.

## Interface
- ADDR_W, 16, byte-address bits used; memory holds 2^(ADDR_W-2) 32-bit words, upper address bits ignored (aliasing).
- LATENCY, 2, cycles from accept edge to data_ok; legal range 1..15.
- OUTSTANDING, 4, max accepted-but-unanswered requests; power of 2, 2..8.
- clk  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  1  initiator request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 byte, 1 halfword, 2 word; 3 treated as word.
- addr  in  32  byte address.
- wdata  in  32  write data, already lane-aligned by the initiator.
- addr_ok  out  1  request accepted this cycle when req && addr_ok.
- rdata  out  32  read data, valid only with data_ok; full word returned.
- data_ok  out  1  one-cycle response pulse, strictly in acceptance order.

## Operation
- Queue: circular buffer, OUTSTANDING entries, each holding {wr, rdata, countdown[3:0]}; head/tail pointers plus count (width log2(OUTSTANDING)+1).
- addr_ok = resetn && (count < OUTSTANDING || pop), where pop = data_ok. Accept and pop in the same cycle when full is legal; count is unchanged.
- On accept: write requests update memory immediately under byte enables; read requests read memory at the same edge, after any same-cycle write (none possible; one port). Entry enqueued with countdown = LATENCY-1.
- Byte enables: size 0 → 4'b0001<<addr[1:0]; size 1 → addr[1] ? 4'b1100 : 4'b0011; size 2/3 → 4'b1111. addr[1:0] is ignored for words, addr[0] for halfwords.
- Every cycle, all valid entries with countdown != 0 decrement.
- data_ok = count != 0 && head.countdown == 0. rdata = head.rdata for reads, 32'h0 for writes. The initiator must accept data_ok unconditionally; there is no back-pressure.
- Ordering: because memory is accessed at acceptance, read-after-write to the same address returns the new data regardless of latency.
- Reset (async assert): count, pointers, and countdowns are cleared; addr_ok=0, data_ok=0, rdata=0. Memory contents are not reset. In-flight requests are dropped and never answered.

## Timing
- Accept at edge T → data_ok high during cycle T+LATENCY-1 after the edge, i.e. sampled at edge T+LATENCY.
- LATENCY=1: response in the cycle immediately after accept.
- Sustained throughput is 1 request/cycle iff LATENCY ≤ OUTSTANDING. Otherwise addr_ok drops when count reaches OUTSTANDING, and throughput is OUTSTANDING/LATENCY.
- addr_ok and data_ok are combinational from registered state only; no combinational path exists from req to addr_ok.
- The first cycle after resetn deassertion has addr_ok=1, except as noted under Configuration.

## Configuration
- SRAM_LIKE_RAND_STALL_EN: when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - addr_ok is additionally forced low when lfsr[1:0]==2'b00.
  - data_ok is held off (countdown frozen at 0) when lfsr[3:2]==2'b00. Order is still preserved.
- When not defined: the LFSR is absent and timing is exactly as stated above.

## Test plan
- Word write then read, LATENCY=2: write 0x100←0xDEADBEEF, then read 0x100 → two data_ok pulses exactly 2 cycles after each accept; second rdata=0xDEADBEEF.
- Sub-word writes: word 0x200←0, byte 0x202←0x00AB0000 (size 0), half 0x200←0x00001234 (size 1) → read 0x200 returns 0x00AB1234.
- Back-to-back reads, LATENCY=4, OUTSTANDING=4: req held for 8 cycles → addr_ok never drops; 8 consecutive data_ok pulses in order.
- Full queue, LATENCY=8, OUTSTANDING=4: continuous req → addr_ok low after 4 accepts, high again in the cycle of the first data_ok; 4 accepts per 8 cycles.
- Reset mid-flight: 3 reads accepted, resetn low for 1 cycle → no data_ok ever follows; addr_ok=0 during reset, 1 after.
- With SRAM_LIKE_RAND_STALL_EN: 1000 random reads/writes checked against a scoreboard → all responses in order with correct data; at least one addr_ok stall observed.
